// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the IF stage
// (instruction fetch) and the MEM stage (lw/sw) of the five-stage pipeline.
// A single transaction is granted at a time. Data accesses win over fetches
// because they belong to the older instruction.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   if_req/if_addr    fetch request and address from IF
//   if_inst           last fetched instruction
//   if_stall          hold IF/ID until the fetch completes (or data stall)
//   dm_rd/dm_wr       load / store request from MEM (both set = store)
//   dm_addr/dm_wdata  data address and store data
//   dm_rdata          last load data
//   dm_stall          hold the whole pipeline until the data access completes
//   mem_*             memory-side request/acknowledge handshake
//   timeout_err       sticky flag: an access was aborted after TIMEOUT cycles
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_inst,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StData, StFetch} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          if_done_q;
  logic          dm_done_q;

  // The done pulse releases the stall in the cycle the pipeline advances.
  assign dm_stall = (dm_rd | dm_wr) & ~dm_done_q;
  assign if_stall = (if_req & ~if_done_q) | dm_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_inst     <= '0;
      dm_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Done flags are single-cycle pulses.
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // A requester in its done cycle still shows the old access; skip it.
          if ((dm_rd | dm_wr) && !dm_done_q) begin
            state_q   <= StData;
            mem_req   <= 1'b1;
            mem_we    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (if_req && !if_done_q) begin
            state_q  <= StFetch;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end else begin
            mem_req <= 1'b0;
          end
        end
        StData, StFetch: begin
          if (mem_ack) begin
            // Ack takes precedence over a coincident timeout.
            state_q <= StIdle;
            mem_req <= 1'b0;
            cnt_q   <= '0;
            if (state_q == StData) begin
              dm_done_q <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
            end else begin
              if_done_q <= 1'b1;
              if_inst   <= mem_rdata;
            end
          end else if (cnt_q == CntLast) begin
            // Abort so the pipeline cannot hang; owner sees zero data.
            state_q     <= StIdle;
            mem_req     <= 1'b0;
            cnt_q       <= '0;
            timeout_err <= 1'b1;
            if (state_q == StData) begin
              dm_done_q <= 1'b1;
              if (!mem_we) dm_rdata <= '0;
            end else begin
              if_done_q <= 1'b1;
              if_inst   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the five-stage pipeline.
- Grants one transaction at a time and drives the memory-side request/acknowledge handshake.
- Returns fetched instructions and load data to the stages.
- Produces per-stage stall signals that the pipeline uses as register hold, so a stage holds until its access completes.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles waiting for mem_ack before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_req  in  1  IF stage wants an instruction at if_addr
if_addr  in  AW  fetch address (pc)
if_inst  out  DW  last fetched instruction
if_stall  out  1  hold IF/ID (fetch not complete)
dm_rd  in  1  MEM stage load (memread_s4)
dm_wr  in  1  MEM stage store (memwrite_s4)
dm_addr  in  AW  data address (ALU result in MEM)
dm_wdata  in  DW  store data
dm_rdata  out  DW  last load data
dm_stall  out  1  hold whole pipeline (data access not complete)
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completes current request (single-cycle pulse)
timeout_err  out  1  sticky: an access was aborted on timeout

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE; mem_req, mem_we, if_done, dm_done and timeout_err are 0; mem_addr, mem_wdata, if_inst, dm_rdata and the wait counter are 0.
- Reset mid-transaction abandons the access. An ack arriving while in IDLE is ignored.
- FSM states: IDLE, DATA, FETCH.
- IDLE arbitration uses fixed priority; data wins because it belongs to the older instruction:
  - If (dm_rd|dm_wr) and !dm_done: go to DATA. Latch mem_addr=dm_addr, mem_wdata=dm_wdata, mem_we=dm_wr. Set mem_req=1.
  - Else if if_req and !if_done: go to FETCH. Latch mem_addr=if_addr, mem_we=0. Set mem_req=1.
  - Else stay in IDLE with mem_req=0.
- If dm_rd and dm_wr are both 1, the access is a write.
- DATA/FETCH: mem_req, mem_addr, mem_we and mem_wdata are held stable. The wait counter increments each cycle.
- On mem_ack=1:
  - Go to IDLE, deassert mem_req and clear the counter.
  - DATA: dm_rdata<=mem_rdata (loads only; stores leave dm_rdata unchanged), dm_done<=1.
  - FETCH: if_inst<=mem_rdata, if_done<=1.
- The done flags are single-cycle pulses; they clear on the next clock. In the done cycle the owning requester is excluded from arbitration, because the pipeline advances that cycle and its request inputs still show the old access.
- Stalls are combinational:
  - dm_stall = (dm_rd|dm_wr) & !dm_done
  - if_stall = if_req & !if_done, OR dm_stall
- Minimum latency is 3 cycles from request to done pulse: IDLE grant, req cycle with ack, done. Each further cycle of ack delay adds one cycle.
- Timeout: if the counter reaches TIMEOUT-1 with no ack:
  - Go to IDLE and deassert mem_req.
  - Set timeout_err=1 (sticky until rst).
  - Pulse the owner's done flag and load its data register with 0, so the pipeline cannot hang.
- An ack in the same cycle as the timeout counts as ack, not timeout.
- The block never issues two requests without an intervening IDLE cycle with mem_req=0.
- Counter width is clog2(TIMEOUT)+1. It wraps only via clear.

Test Plan:
- Reset, then if_req=1, if_addr=0x00000004, ack one cycle after mem_req with rdata=0x20080005 -> mem_req/mem_addr=0x4/mem_we=0 for 1 cycle, if_inst=0x20080005, if_done pulse, if_stall low exactly that cycle.
- Simultaneous if_req (addr 0x8) and dm_rd (addr 0x40, rdata 0x1234): 0x40 is issued first, dm_rdata=0x1234; fetch of 0x8 starts the cycle after dm_done, if_stall stays high throughout.
- Store dm_wr=1, dm_addr=0x44, dm_wdata=0xDEADBEEF, ack delayed 4 cycles -> mem_we=1 and mem_addr/mem_wdata stable for all 5 req cycles, dm_stall high until the done pulse, dm_rdata unchanged.
- No ack with TIMEOUT=16 -> mem_req drops after 16 cycles, timeout_err=1 and stays 1, owner data=0, done pulse; the next access proceeds normally with timeout_err still 1.
- Assert rst while in DATA with mem_req=1 -> all outputs 0 asynchronously; a late mem_ack after rst is released changes nothing.
- Continuous if_req with a changing if_addr and immediate acks -> one fetch per 3 cycles, mem_req low for at least 1 cycle between accesses, no repeat fetch of an address during its done cycle.
